branch_pc_unit: RTL and testbench

- Program-counter register plus a small branch-resolution sequencer. It sits directly downstream of the condition flip-flop (CONN_FF) in the datapath.
- It drives the condition FF's enable (conn_in), samples its result (conn_out), and commits PC = PC + sign-extended C when the branch is taken.
- Outside a branch it handles normal PC load-from-bus and increment during fetch.

---
 rtl/branch_pc_unit.sv | 97 +++++++++
 tb/tb_branch_pc_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// Program counter with a four-state branch sequencer that drives CONN_FF and
// commits PC + sign-extended displacement when the sampled condition is true.
module branch_pc_unit #(
   parameter logic [31:0] PC_RESET  = 32'h0000_0000,
   parameter int          OFFSET_W  = 19,
   parameter logic [4:0]  BR_OPCODE = 5'b10010
) (
   input  logic        clk,
   input  logic        clear,
   input  logic [31:0] ir_data,
   input  logic [31:0] bus_mux_out,
   input  logic        pc_in,
   input  logic        pc_inc,
   input  logic        br_start,
   input  logic        conn_out,
   output logic        conn_in,
   output logic [31:0] pc_out,
   output logic        busy,
   output logic        br_taken,
   output logic        done,
   output logic        illegal
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EVAL    = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_pc;
   logic [31:0] r_off;
   logic        r_con;
   logic        r_illegal;

   logic        w_isBranch;
   logic        w_accept;
   logic [31:0] w_offExt;
   logic        w_unusedIr;

   assign w_isBranch = (ir_data[31:27] == BR_OPCODE);
   assign w_accept   = (r_state == IDLE) && br_start && w_isBranch;
   assign w_offExt   = {{(32-OFFSET_W){ir_data[OFFSET_W-1]}}, ir_data[OFFSET_W-1:0]};
   assign w_unusedIr = ^ir_data;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = EVAL;
         EVAL:    w_nextState = RESOLVE;
         RESOLVE: w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      conn_in  = (r_state == EVAL);
      busy     = (r_state != IDLE);
      br_taken = (r_state == RESOLVE) && r_con;
      done     = (r_state == DONE);
      illegal  = r_illegal;
      pc_out   = r_pc;
   end

   // Bus/increment updates only land in IDLE; a branch commits at the RESOLVE->DONE edge.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_pc <= PC_RESET;
      end else if (r_state == IDLE) begin
         if (pc_in)       r_pc <= bus_mux_out;
         else if (pc_inc) r_pc <= r_pc + 32'd1;
      end else if ((r_state == RESOLVE) && r_con) begin
         r_pc <= r_pc + r_off;
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_off     <= 32'd0;
         r_con     <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         if (w_accept)           r_off <= w_offExt;
         if (r_state == EVAL)    r_con <= conn_out;
         r_illegal <= (r_state == IDLE) && br_start && !w_isBranch;
      end
   end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: reset, PC load/increment, taken/not-taken
// branches, illegal opcodes, busy-time input masking and start+increment overlap.
module tb_branch_pc_unit;

   logic        clk;
   logic        clear;
   logic [31:0] ir_data;
   logic [31:0] bus_mux_out;
   logic        pc_in;
   logic        pc_inc;
   logic        br_start;
   logic        conn_out;
   logic        conn_in;
   logic [31:0] pc_out;
   logic        busy;
   logic        br_taken;
   logic        done;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   branch_pc_unit dut (
      .clk         (clk),
      .clear       (clear),
      .ir_data     (ir_data),
      .bus_mux_out (bus_mux_out),
      .pc_in       (pc_in),
      .pc_inc      (pc_inc),
      .br_start    (br_start),
      .conn_out    (conn_out),
      .conn_in     (conn_in),
      .pc_out      (pc_out),
      .busy        (busy),
      .br_taken    (br_taken),
      .done        (done),
      .illegal     (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic loadPc(input logic [31:0] value);
      pc_in = 1'b1;
      bus_mux_out = value;
      step();
      pc_in = 1'b0;
   endtask

   function automatic logic [31:0] brIr(input logic [18:0] off);
      brIr = {5'b10010, 8'h00, off};
   endfunction

   task automatic test_reset();
      #1 clear = 1'b1;
      #1;
      checks++;
      if (pc_out !== 32'h0 || busy !== 1'b0 || conn_in !== 1'b0 || done !== 1'b0 ||
          br_taken !== 1'b0 || illegal !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: pc=%h busy=%b conn_in=%b done=%b taken=%b illegal=%b expected all 0",
                  pc_out, busy, conn_in, done, br_taken, illegal);
      end
      #1 clear = 1'b0;
      loadPc(32'h0000_0055);
      ir_data = brIr(19'h00004);
      conn_out = 1'b1;
      br_start = 1'b1;
      step();
      br_start = 1'b0;
      checks++;
      if (conn_in !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_pre_eval: conn_in=%b busy=%b expected 1 1", conn_in, busy);
      end
      clear = 1'b1;
      #1;
      checks++;
      if (pc_out !== 32'h0 || busy !== 1'b0 || conn_in !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mid_eval: pc=%h busy=%b conn_in=%b expected 0 0 0", pc_out, busy, conn_in);
      end
      #1 clear = 1'b0;
      step();
      checks++;
      if (pc_out !== 32'h0 || done !== 1'b0 || br_taken !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_abort: pc=%h done=%b taken=%b expected 0 0 0", pc_out, done, br_taken);
      end
      pc_inc = 1'b1;
      step();
      pc_inc = 1'b0;
      checks++;
      if (pc_out !== 32'h1) begin
         errors++;
         $display("[TB] FAIL reset_first_inc: pc=%h expected 00000001", pc_out);
      end
   endtask

   task automatic test_load_inc();
      loadPc(32'h0000_0040);
      checks++;
      if (pc_out !== 32'h40) begin
         errors++;
         $display("[TB] FAIL load_40: pc=%h expected 00000040", pc_out);
      end
      pc_in = 1'b1;
      pc_inc = 1'b1;
      bus_mux_out = 32'h80;
      step();
      pc_in = 1'b0;
      pc_inc = 1'b0;
      checks++;
      if (pc_out !== 32'h80) begin
         errors++;
         $display("[TB] FAIL load_priority: pc=%h expected 00000080", pc_out);
      end
      pc_inc = 1'b1;
      step();
      pc_inc = 1'b0;
      checks++;
      if (pc_out !== 32'h81) begin
         errors++;
         $display("[TB] FAIL inc_81: pc=%h expected 00000081", pc_out);
      end
      loadPc(32'hFFFF_FFFF);
      pc_inc = 1'b1;
      step();
      pc_inc = 1'b0;
      checks++;
      if (pc_out !== 32'h0) begin
         errors++;
         $display("[TB] FAIL inc_wrap: pc=%h expected 00000000", pc_out);
      end
   endtask

   task automatic test_taken_backward();
      loadPc(32'h10);
      ir_data = brIr(19'h7FFFE);
      conn_out = 1'b1;
      br_start = 1'b1;
      step();
      br_start = 1'b0;
      ir_data = brIr(19'h00100);
      checks++;
      if (busy !== 1'b1 || conn_in !== 1'b1 || br_taken !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL taken_eval: busy=%b conn_in=%b taken=%b done=%b expected 1 1 0 0",
                  busy, conn_in, br_taken, done);
      end
      step();
      checks++;
      if (br_taken !== 1'b1 || conn_in !== 1'b0 || pc_out !== 32'h10 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL taken_resolve: taken=%b conn_in=%b pc=%h done=%b expected 1 0 00000010 0",
                  br_taken, conn_in, pc_out, done);
      end
      step();
      checks++;
      if (done !== 1'b1 || br_taken !== 1'b0 || pc_out !== 32'h0E || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL taken_done: done=%b taken=%b pc=%h busy=%b expected 1 0 0000000e 1",
                  done, br_taken, pc_out, busy);
      end
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pc_out !== 32'h0E) begin
         errors++;
         $display("[TB] FAIL taken_idle: busy=%b done=%b pc=%h expected 0 0 0000000e", busy, done, pc_out);
      end
   endtask

   task automatic test_not_taken();
      int takenSeen;
      takenSeen = 0;
      loadPc(32'h10);
      ir_data = brIr(19'h00005);
      conn_out = 1'b1;
      br_start = 1'b1;
      step();
      br_start = 1'b0;
      conn_out = 1'b0;
      if (br_taken === 1'b1) takenSeen++;
      step();
      conn_out = 1'b1;
      if (br_taken === 1'b1) takenSeen++;
      step();
      if (br_taken === 1'b1) takenSeen++;
      checks++;
      if (done !== 1'b1 || pc_out !== 32'h10) begin
         errors++;
         $display("[TB] FAIL nottaken_done: done=%b pc=%h expected 1 00000010", done, pc_out);
      end
      step();
      checks++;
      if (takenSeen !== 0 || pc_out !== 32'h10 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL nottaken_idle: taken_cycles=%0d pc=%h busy=%b expected 0 00000010 0",
                  takenSeen, pc_out, busy);
      end
   endtask

   task automatic test_illegal_busy();
      ir_data = {5'b00011, 27'h0000005};
      br_start = 1'b1;
      step();
      br_start = 1'b0;
      checks++;
      if (illegal !== 1'b1 || busy !== 1'b0 || pc_out !== 32'h10) begin
         errors++;
         $display("[TB] FAIL illegal_pulse: illegal=%b busy=%b pc=%h expected 1 0 00000010",
                  illegal, busy, pc_out);
      end
      step();
      checks++;
      if (illegal !== 1'b0 || pc_out !== 32'h10) begin
         errors++;
         $display("[TB] FAIL illegal_clear: illegal=%b pc=%h expected 0 00000010", illegal, pc_out);
      end
      ir_data = brIr(19'h00004);
      conn_out = 1'b1;
      br_start = 1'b1;
      step();
      pc_in = 1'b1;
      pc_inc = 1'b1;
      bus_mux_out = 32'h0000_0999;
      ir_data = {5'b00011, 27'h0};
      step();
      br_start = 1'b0;
      pc_in = 1'b0;
      pc_inc = 1'b0;
      checks++;
      if (pc_out !== 32'h10 || br_taken !== 1'b1 || illegal !== 1'b0) begin
         errors++;
         $display("[TB] FAIL busy_ignore: pc=%h taken=%b illegal=%b expected 00000010 1 0",
                  pc_out, br_taken, illegal);
      end
      step();
      checks++;
      if (pc_out !== 32'h14 || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL busy_result: pc=%h done=%b expected 00000014 1", pc_out, done);
      end
      step();
      checks++;
      if (pc_out !== 32'h14 || busy !== 1'b0 || illegal !== 1'b0) begin
         errors++;
         $display("[TB] FAIL busy_after: pc=%h busy=%b illegal=%b expected 00000014 0 0",
                  pc_out, busy, illegal);
      end
   endtask

   task automatic test_start_inc();
      loadPc(32'h20);
      ir_data = brIr(19'h00003);
      conn_out = 1'b1;
      br_start = 1'b1;
      pc_inc = 1'b1;
      step();
      br_start = 1'b0;
      pc_inc = 1'b0;
      checks++;
      if (pc_out !== 32'h21 || conn_in !== 1'b1) begin
         errors++;
         $display("[TB] FAIL startinc_eval: pc=%h conn_in=%b expected 00000021 1", pc_out, conn_in);
      end
      step();
      step();
      checks++;
      if (pc_out !== 32'h24 || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL startinc_done: pc=%h done=%b expected 00000024 1", pc_out, done);
      end
      step();
   endtask

   task automatic test_back_to_back();
      ir_data = brIr(19'h00001);
      conn_out = 1'b1;
      br_start = 1'b1;
      step();
      br_start = 1'b0;
      step();
      step();
      step();
      ir_data = brIr(19'h7FFF0);
      br_start = 1'b1;
      step();
      br_start = 1'b0;
      checks++;
      if (pc_out !== 32'h25 || busy !== 1'b1 || conn_in !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_second_start: pc=%h busy=%b conn_in=%b expected 00000025 1 1",
                  pc_out, busy, conn_in);
      end
      step();
      step();
      checks++;
      if (pc_out !== 32'h15 || done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_result: pc=%h done=%b expected 00000015 1", pc_out, done);
      end
      step();
   endtask

   initial begin
      clear = 1'b0;
      ir_data = 32'h0;
      bus_mux_out = 32'h0;
      pc_in = 1'b0;
      pc_inc = 1'b0;
      br_start = 1'b0;
      conn_out = 1'b0;
      $display("[TB] starting branch_pc_unit bench");
      test_reset();
      test_load_inc();
      test_taken_backward();
      test_not_taken();
      test_illegal_busy();
      test_start_inc();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
